// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle: datapath-side register/control taps in, stall/flush/forward controls out.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic [REG_AW-1:0] RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic              LoadE, PCSrcE, McStartE;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              McLaunch, McBusy, McDone;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, McLaunch, McBusy, McDone, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, McLaunch, McBusy, McDone, StallCount
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Five-stage pipeline hazard unit: EX forwarding, load-use stall, branch flush,
// multi-cycle execute hold for MUL/DIV and a saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  hazard_unit_mc_if.slave hazardBus
);
  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(MC_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, BUSY} mcState_t;

  mcState_t         state, stateNext;
  logic [CW-1:0]    cnt, cntNext;
  logic             mcStall, mcLaunch, mcDone;
  logic             lwStall, stallAny;
  logic [CNT_W-1:0] stallCount;

  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdM,
    input logic              regWriteM,
    input logic [REG_AW-1:0] rdW,
    input logic              regWriteW
  );
    if (regWriteM && (rdM == rs) && (rs != '0))      return 2'b10;
    else if (regWriteW && (rdW == rs) && (rs != '0)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign hazardBus.ForwardAE = fwdSel(hazardBus.Rs1E, hazardBus.RdM, hazardBus.RegWriteM,
                                      hazardBus.RdW, hazardBus.RegWriteW);
  assign hazardBus.ForwardBE = fwdSel(hazardBus.Rs2E, hazardBus.RdM, hazardBus.RegWriteM,
                                      hazardBus.RdW, hazardBus.RegWriteW);

  assign lwStall = hazardBus.LoadE && (hazardBus.RdE != '0) &&
                   ((hazardBus.Rs1D == hazardBus.RdE) || (hazardBus.Rs2D == hazardBus.RdE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Launch is gated by rst so nothing reaches the execute unit while reset is held.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mcStall   = 1'b0;
    mcLaunch  = 1'b0;
    mcDone    = 1'b0;
    case (state)
      IDLE: begin
        if (rst && hazardBus.McStartE) begin
          mcLaunch  = 1'b1;
          mcStall   = 1'b1;
          stateNext = BUSY;
          cntNext   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          mcStall = 1'b1;
          cntNext = cnt - 1'b1;
        end else begin
          mcDone    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign stallAny = lwStall | mcStall;

  assign hazardBus.StallF   = stallAny;
  assign hazardBus.StallD   = stallAny;
  assign hazardBus.StallE   = mcStall;
  assign hazardBus.FlushD   = hazardBus.PCSrcE & ~mcStall;
  assign hazardBus.FlushE   = (lwStall | hazardBus.PCSrcE) & ~mcStall;
  assign hazardBus.FlushM   = mcStall;
  assign hazardBus.McLaunch = mcLaunch;
  assign hazardBus.McBusy   = (state == BUSY);
  assign hazardBus.McDone   = mcDone;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stallCount <= '0;
    else if (stallAny && (stallCount != CNT_MAX))
      stallCount <= stallCount + 1'b1;
  end

  assign hazardBus.StallCount = stallCount;
endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised pipeline hazard unit for the five-stage RISC-V core, successor to the single-cycle hazard logic. It keeps EX-stage forwarding, load-use stall and taken-branch flush. It adds a multi-cycle execute mode for MUL/DIV, in which a counter-driven FSM holds the front of the pipeline and injects bubbles into MEM. It also adds a saturating stall-cycle performance counter. It sits beside the datapath and drives the stall, flush and forward-select inputs of the pipeline registers.

## Interface
Parameters:
- REG_AW, 5, register address width
- MC_LAT, 4, execute-stage occupancy in cycles of a multi-cycle op; legal range ≥ 2
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- Rs1D, Rs2D  in  REG_AW  source registers in decode
- Rs1E, Rs2E, RdE  in  REG_AW  source and destination registers in execute
- RdM, RdW  in  REG_AW  destination registers in memory and writeback
- RegWriteM, RegWriteW  in  1  write enables in memory and writeback
- LoadE  in  1  execute-stage instruction is a load (ResultSrcE bit 0)
- PCSrcE  in  1  taken branch or jump resolved in execute
- McStartE  in  1  execute-stage instruction is multi-cycle
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1  clear IF/ID, ID/EX and EX/MEM to a bubble
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 writeback, 10 memory
- McLaunch  out  1  execute unit latches its operands this cycle
- McBusy  out  1  FSM is in state BUSY
- McDone  out  1  final cycle of a multi-cycle op
- StallCount  out  CNT_W  number of cycles with StallF high, saturating

## Operation
Forwarding (combinational):
- ForwardAE = 10 if RegWriteM and RdM == Rs1E and Rs1E != 0.
- Otherwise ForwardAE = 01 if RegWriteW and RdW == Rs1E and Rs1E != 0.
- Otherwise ForwardAE = 00.
- ForwardBE uses the same rules with Rs2E.
- MEM has priority over WB. x0 is never forwarded.

Load-use stall:
- lwStall = LoadE & (RdE != 0) & ((Rs1D == RdE) | (Rs2D == RdE)).

Multi-cycle FSM. States are IDLE and BUSY, with a down-counter cnt of width clog2(MC_LAT).
- IDLE with McStartE = 1: McLaunch = 1 and mcStall = 1. Next state is BUSY with cnt = MC_LAT-2.
- IDLE with McStartE = 1 and MC_LAT = 2: next state is BUSY with cnt = 0.
- BUSY with cnt != 0: mcStall = 1 and cnt decrements.
- BUSY with cnt == 0: McDone = 1 and mcStall = 0. Next state is IDLE.
- McStartE is ignored in BUSY, because the same instruction is held in execute.
- A multi-cycle op therefore occupies execute for exactly MC_LAT cycles.

Output equations:
- StallF = StallD = lwStall | mcStall.
- StallE = mcStall.
- FlushD = PCSrcE & ~mcStall.
- FlushE = (lwStall | PCSrcE) & ~mcStall.
- FlushM = mcStall.
- McBusy = (state == BUSY).

Decode and conflict rules:
- LoadE, PCSrcE and McStartE are mutually exclusive by decode.
- If McStartE and PCSrcE are both asserted in IDLE, the multi-cycle op wins and PCSrcE is masked.

StallCount:
- Increments on every clock edge where StallF = 1.
- Holds at 2^CNT_W − 1 once it saturates.

## Timing
- Forward selects, lwStall and all stall/flush outputs are combinational from the inputs and the current state, with no added latency.
- mcStall is asserted in the same cycle that McStartE is first seen in IDLE.
- Forward selects are only guaranteed meaningful in the McLaunch cycle, so the execute unit captures its operands then.
- Reset (rst low) takes effect immediately, independent of clk. While rst is low and after release:
  - state = IDLE, cnt = 0, StallCount = 0.
  - mcStall, McLaunch, McBusy and McDone are 0.
  - The combinational outputs follow the inputs with mcStall = 0.
- Reset asserted mid-op aborts the op. On release the FSM is in IDLE and samples McStartE afresh on the next edge.
- A McStartE that is still high in the McDone cycle does not relaunch. The next launch requires IDLE plus a new instruction in execute.

## Test plan
- Rs1E = 5, RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1 -> ForwardAE = 10. Repeat with Rs1E = 0 -> ForwardAE = 00.
- LoadE = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1, StallE = 0. Repeat with RdE = 0 -> all 0.
- MC_LAT = 4, McStartE held high from cycle 0:
  - cycles 0–2: StallF/D/E = 1 and FlushM = 1.
  - cycle 0: McLaunch = 1.
  - cycle 3: McDone = 1, stalls = 0.
  - cycle 4: IDLE.
- PCSrcE = 1 in IDLE -> FlushD = FlushE = 1. PCSrcE = 1 during BUSY -> FlushD = FlushE = 0.
- rst low at cycle 2 of a 4-cycle op -> McBusy = 0 and StallE = 0 immediately. StallCount = 0 after release.
- CNT_W = 4, stall held for 20 cycles -> StallCount stops at 15.
